frame_pixel_streamer: RTL and testbench

Frame-buffer reader that produces the raster gray-pixel stream (`gray_valid`/`gray`) consumed by the 5x5 Gaussian filter and other line-buffer-based stages. On a start pulse it reads one `IMAGE_WIDTH`×`IMAGE_HEIGHT` frame from a synchronous 1-cycle-latency RAM in raster order. It inserts programmable horizontal blanking between rows, then appends `FLUSH_ROWS` rows of pad pixels so the downstream window filter can emit its final output rows. The block is the transmit end of the pixel-stream interface and has no downstream back-pressure.

---
 rtl/pixel_stream_pkg.sv | 27 ++
 rtl/pixel_fetch_pipe.sv | 72 +++++++
 rtl/frame_pixel_streamer.sv | 155 +++++++++++++++
 tb/tb_frame_pixel_streamer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_stream_pkg
// Purpose  : Shared types and helpers for the raster pixel-stream blocks.
//            Holds the streamer state encoding, the pixel width and a
//            clog2 helper that never returns a zero-width result.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pixel_stream_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BLANK = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Address widths must be at least one bit even for a 1- or 2-entry RAM.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_fetch_pipe.sv
`default_nettype none
// ============================================================================
// Module   : pixel_fetch_pipe
// Purpose  : Two-stage pipeline that carries {valid, pad, row, col} alongside
//            a 1-cycle-latency RAM read and registers the final pixel.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            issue_*           - per-cycle issue strobe, pad flag, row, col
//            mem_rdata         - RAM data, aligned with stage 1
//            s1_valid          - stage-1 occupancy (for drain detection)
//            gray_valid, gray  - output pixel strobe and value
//            out_row, out_col  - coordinates of the output pixel
// Revision : 1.0 - initial release
// ============================================================================
module pixel_fetch_pipe
  import pixel_stream_pkg::*;
#(
  parameter logic [PIX_W-1:0] PAD_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic             issue_pad,
  input  logic [15:0]      issue_row,
  input  logic [15:0]      issue_col,
  input  logic [PIX_W-1:0] mem_rdata,
  output logic             s1_valid,
  output logic             gray_valid,
  output logic [PIX_W-1:0] gray,
  output logic [15:0]      out_row,
  output logic [15:0]      out_col
);

  logic        s1_pad;
  logic [15:0] s1_row;
  logic [15:0] s1_col;

  // Stage 1: lines up with the RAM data returned for the previous issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pad   <= 1'b0;
      s1_row   <= '0;
      s1_col   <= '0;
    end else begin
      s1_valid <= issue_valid;
      if (issue_valid) begin
        s1_pad <= issue_pad;
        s1_row <= issue_row;
        s1_col <= issue_col;
      end
    end
  end

  // Stage 2: data and coordinates hold their last value between pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_valid <= 1'b0;
      gray       <= '0;
      out_row    <= '0;
      out_col    <= '0;
    end else begin
      gray_valid <= s1_valid;
      if (s1_valid) begin
        gray    <= s1_pad ? PAD_VALUE : mem_rdata;
        out_row <= s1_row;
        out_col <= s1_col;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module   : frame_pixel_streamer
// Purpose  : Reads one IMAGE_WIDTH x IMAGE_HEIGHT frame from a 1-cycle RAM in
//            raster order, inserts HBLANK idle cycles between rows and appends
//            FLUSH_ROWS rows of PAD_VALUE pixels for downstream window filters.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            start               - begin a frame (only honoured in IDLE)
//            pause               - freeze issue and all counters
//            mem_rd, mem_addr    - frame RAM read strobe / address
//            mem_rdata           - RAM data, valid the cycle after mem_rd
//            gray_valid, gray    - output pixel stream
//            out_row, out_col    - coordinates of the current output pixel
//            busy, done          - frame in progress / end-of-frame pulse
// Revision : 1.0 - initial release
// ============================================================================
module frame_pixel_streamer
  import pixel_stream_pkg::*;
#(
  parameter int               IMAGE_WIDTH  = 320,
  parameter int               IMAGE_HEIGHT = 240,
  parameter int               HBLANK       = 4,
  parameter int               FLUSH_ROWS   = 2,
  parameter logic [PIX_W-1:0] PAD_VALUE    = 8'd0,
  localparam int              ADDR_W       = clog2_min1(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic              gray_valid,
  output logic [PIX_W-1:0]  gray,
  output logic [15:0]       out_row,
  output logic [15:0]       out_col,
  output logic              busy,
  output logic              done
);

  localparam int          LAST_ROW   = IMAGE_HEIGHT + FLUSH_ROWS - 1;
  localparam logic [15:0] BLANK_LAST = 16'((HBLANK > 0) ? HBLANK - 1 : 0);

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       row;
  logic [15:0]       col;
  logic [15:0]       blank_cnt;
  logic [ADDR_W-1:0] addr;
  logic              issue;
  logic              flush_row;
  logic              row_end;
  logic              last_row;
  logic              blank_end;
  logic              s1_valid;
  logic              pipe_empty;

  assign flush_row  = (row >= 16'(IMAGE_HEIGHT));
  assign row_end    = (col == 16'(IMAGE_WIDTH - 1));
  assign last_row   = (row == 16'(LAST_ROW));
  assign blank_end  = (blank_cnt == BLANK_LAST);
  assign pipe_empty = !s1_valid && !gray_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!pause) begin
          issue = 1'b1;
          if (row_end) begin
            if (last_row)         state_nxt = ST_DRAIN;
            else if (HBLANK == 0) state_nxt = ST_ISSUE;
            else                  state_nxt = ST_BLANK;
          end
        end
      end
      ST_BLANK: begin
        if (!pause && blank_end) state_nxt = ST_ISSUE;
      end
      ST_DRAIN: begin
        // done lands on the first cycle with nothing left in either stage.
        if (pipe_empty) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy     = (state == ST_ISSUE) || (state == ST_BLANK) ||
                    ((state == ST_DRAIN) && !pipe_empty);
  assign mem_rd   = issue && !flush_row;
  assign mem_addr = addr;

  // Raster counters; the address simply increments over image pixels, so
  // no row*width multiply is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      row       <= '0;
      col       <= '0;
      addr      <= '0;
      blank_cnt <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        row       <= '0;
        col       <= '0;
        addr      <= '0;
        blank_cnt <= '0;
      end
      if (issue) begin
        if (!flush_row) addr <= addr + ADDR_W'(1);
        if (row_end) begin
          col <= '0;
          if (!last_row) row <= row + 16'd1;
        end else begin
          col <= col + 16'd1;
        end
      end
      if (state == ST_BLANK && !pause) begin
        blank_cnt <= blank_end ? 16'd0 : blank_cnt + 16'd1;
      end
    end
  end

  pixel_fetch_pipe #(
    .PAD_VALUE (PAD_VALUE)
  ) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue),
    .issue_pad  (flush_row),
    .issue_row  (row),
    .issue_col  (col),
    .mem_rdata  (mem_rdata),
    .s1_valid   (s1_valid),
    .gray_valid (gray_valid),
    .gray       (gray),
    .out_row    (out_row),
    .out_col    (out_col)
  );

endmodule
`default_nettype wire

// File: tb/tb_frame_pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_pixel_streamer
// Purpose  : Self-checking bench for frame_pixel_streamer. Three instances
//            (W=4,H=3): main (HBLANK=2,F=2), no-blank (HBLANK=0,F=2) and
//            pad/no-flush (HBLANK=2,F=0,PAD=A5). RAM contents are random and
//            expectations come from a slot-based schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_pixel_streamer;

  localparam int W = 4;
  localparam int H = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic pause = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram [0:15];

  logic a_rd, a_gv, a_busy, a_done; logic [3:0] a_addr; logic [7:0] a_rdata, a_g; logic [15:0] a_row, a_col;
  logic b_rd, b_gv, b_busy, b_done; logic [3:0] b_addr; logic [7:0] b_rdata, b_g; logic [15:0] b_row, b_col;
  logic c_rd, c_gv, c_busy, c_done; logic [3:0] c_addr; logic [7:0] c_rdata, c_g; logic [15:0] c_row, c_col;

  always @(posedge clk) if (a_rd) a_rdata <= ram[a_addr];
  always @(posedge clk) if (b_rd) b_rdata <= ram[b_addr];
  always @(posedge clk) if (c_rd) c_rdata <= ram[c_addr];

  frame_pixel_streamer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .HBLANK(2), .FLUSH_ROWS(2), .PAD_VALUE(8'h00)) u_dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .mem_rd(a_rd), .mem_addr(a_addr),
    .mem_rdata(a_rdata), .gray_valid(a_gv), .gray(a_g), .out_row(a_row), .out_col(a_col),
    .busy(a_busy), .done(a_done));

  frame_pixel_streamer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .HBLANK(0), .FLUSH_ROWS(2), .PAD_VALUE(8'h00)) u_nohb (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .mem_rd(b_rd), .mem_addr(b_addr),
    .mem_rdata(b_rdata), .gray_valid(b_gv), .gray(b_g), .out_row(b_row), .out_col(b_col),
    .busy(b_busy), .done(b_done));

  frame_pixel_streamer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .HBLANK(2), .FLUSH_ROWS(0), .PAD_VALUE(8'hA5)) u_pad (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .mem_rd(c_rd), .mem_addr(c_addr),
    .mem_rdata(c_rdata), .gray_valid(c_gv), .gray(c_g), .out_row(c_row), .out_col(c_col),
    .busy(c_busy), .done(c_done));

  int vectors = 0;
  int miscompares = 0;
  logic [127:0] st_pat;
  logic [127:0] pz_pat;

  function automatic int hb_of(input int sel);
    return (sel == 1) ? 0 : 2;
  endfunction
  function automatic int fr_of(input int sel);
    return (sel == 2) ? 0 : 2;
  endfunction
  function automatic logic [7:0] pad_of(input int sel);
    return (sel == 2) ? 8'hA5 : 8'h00;
  endfunction

  task automatic sample(input int sel, output logic v, output logic rd, output logic dn,
                        output logic bs, output logic [7:0] g, output logic [15:0] r,
                        output logic [15:0] c, output logic [3:0] ad);
    case (sel)
      0:       begin v = a_gv; rd = a_rd; dn = a_done; bs = a_busy; g = a_g; r = a_row; c = a_col; ad = a_addr; end
      1:       begin v = b_gv; rd = b_rd; dn = b_done; bs = b_busy; g = b_g; r = b_row; c = b_col; ad = b_addr; end
      default: begin v = c_gv; rd = c_rd; dn = c_done; bs = c_busy; g = c_g; r = c_row; c = c_col; ad = c_addr; end
    endcase
  endtask

  task automatic randomize_ram();
    for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
  endtask

  task automatic idle(input int n);
    start = 1'b0; pause = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: a frame is a sequence of issue slots (W pixel slots then HBLANK
  // blank slots per row, no blank after the last row). Each unpaused cycle
  // from cycle 1 consumes one slot; a pixel issued in cycle c appears at c+2.
  task automatic run_frame(input int sel, input logic [127:0] st, input logic [127:0] pz, input int ext);
    int hb, fr, per, total, slot, last, done_c, pr, pc;
    logic ev [128]; int er [128]; int ec [128]; logic erd [128]; int ead [128];
    logic v, rd, dn, bs; logic [7:0] g, eg; logic [15:0] r, c; logic [3:0] ad;
    hb = hb_of(sel); fr = fr_of(sel); per = W + hb; total = per * (H + fr) - hb;
    for (int i = 0; i < 128; i++) begin ev[i] = 0; er[i] = 0; ec[i] = 0; erd[i] = 0; ead[i] = 0; end
    slot = 0; last = -1;
    for (int cy = 1; cy < 120 && slot < total; cy++) begin
      if (!pz[cy]) begin
        if (slot % per < W) begin
          pr = slot / per; pc = slot % per;
          ev[cy+2] = 1'b1; er[cy+2] = pr; ec[cy+2] = pc;
          if (pr < H) begin erd[cy] = 1'b1; ead[cy] = pr * W + pc; end
        end
        slot++;
        if (slot == total) last = cy;
      end
    end
    done_c = last + 3;
    for (int cy = 0; cy <= done_c + ext; cy++) begin
      start = st[cy]; pause = pz[cy];
      @(negedge clk);
      sample(sel, v, rd, dn, bs, g, r, c, ad);
      vectors++;
      if (v !== ev[cy]) begin
        miscompares++;
        $display("FAIL valid inst=%0d cyc=%0d got %b want %b", sel, cy, v, ev[cy]);
      end
      if (ev[cy] && v === 1'b1) begin
        eg = (er[cy] < H) ? ram[er[cy] * W + ec[cy]] : pad_of(sel);
        vectors++;
        if (g !== eg || r !== 16'(er[cy]) || c !== 16'(ec[cy])) begin
          miscompares++;
          $display("FAIL pixel inst=%0d cyc=%0d got %h r%0d c%0d want %h r%0d c%0d",
                   sel, cy, g, r, c, eg, er[cy], ec[cy]);
        end
      end
      vectors++;
      if (rd !== erd[cy] || (erd[cy] && ad !== 4'(ead[cy]))) begin
        miscompares++;
        $display("FAIL mem_rd inst=%0d cyc=%0d got rd=%b addr=%0d want rd=%b addr=%0d",
                 sel, cy, rd, ad, erd[cy], ead[cy]);
      end
      vectors++;
      if (dn !== (cy == done_c)) begin
        miscompares++;
        $display("FAIL done inst=%0d cyc=%0d got %b want %b", sel, cy, dn, (cy == done_c));
      end
      vectors++;
      if (bs !== (cy >= 1 && cy <= last + 2)) begin
        miscompares++;
        $display("FAIL busy inst=%0d cyc=%0d got %b want %b", sel, cy, bs, (cy >= 1 && cy <= last + 2));
      end
      @(posedge clk); #1;
    end
    start = 1'b0; pause = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    vectors++;
    if ({a_rd, a_addr, a_gv, a_g, a_row, a_col, a_busy, a_done} !== '0) begin
      miscompares++;
      $display("FAIL %s rd=%b addr=%0d gv=%b g=%h row=%0d col=%0d busy=%b done=%b want all 0",
               tag, a_rd, a_addr, a_gv, a_g, a_row, a_col, a_busy, a_done);
    end
    vectors++;
    if ({b_gv, c_gv, b_busy, c_busy} !== 4'b0) begin
      miscompares++;
      $display("FAIL %s_others got gv=%b%b busy=%b%b want 0", tag, b_gv, c_gv, b_busy, c_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pause = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    randomize_ram();
    st_pat = '0; st_pat[0] = 1'b1; pz_pat = '0;
    run_frame(0, st_pat, pz_pat, 1);
    idle(5);
  endtask

  task automatic test_pause();
    randomize_ram();
    st_pat = '0; st_pat[0] = 1'b1;
    pz_pat = '0; pz_pat[8] = 1'b1; pz_pat[9] = 1'b1; pz_pat[10] = 1'b1;
    run_frame(0, st_pat, pz_pat, 1);
    idle(5);
    for (int k = 0; k < 3; k++) begin
      randomize_ram();
      pz_pat = '0;
      for (int cy = 1; cy < 45; cy++) pz_pat[cy] = ($urandom_range(0, 3) == 0);
      run_frame(0, st_pat, pz_pat, 1);
      idle(5);
    end
  endtask

  task automatic test_start_while_busy();
    randomize_ram();
    st_pat = '0; st_pat[0] = 1'b1; st_pat[5] = 1'b1; st_pat[31] = 1'b1; pz_pat = '0;
    run_frame(0, st_pat, pz_pat, 0);
    st_pat = '0; st_pat[0] = 1'b1;
    run_frame(0, st_pat, pz_pat, 1);
    idle(40);
  endtask

  task automatic test_no_hblank();
    randomize_ram();
    st_pat = '0; st_pat[0] = 1'b1; pz_pat = '0;
    run_frame(1, st_pat, pz_pat, 1);
    idle(40);
    for (int cy = 1; cy < 30; cy++) pz_pat[cy] = ($urandom_range(0, 4) == 0);
    run_frame(1, st_pat, pz_pat, 1);
    idle(40);
  endtask

  task automatic test_pad_no_flush();
    randomize_ram();
    st_pat = '0; st_pat[0] = 1'b1; pz_pat = '0;
    run_frame(2, st_pat, pz_pat, 1);
    idle(40);
  endtask

  task automatic test_reset_mid();
    logic v, rd, dn, bs; logic [7:0] g; logic [15:0] r, c; logic [3:0] ad;
    randomize_ram();
    for (int cy = 0; cy <= 10; cy++) begin
      start = (cy == 0); rst = (cy == 10);
      @(posedge clk); #1;
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_zero("reset_mid");
    for (int cy = 12; cy < 20; cy++) begin
      @(posedge clk); #1;
      @(negedge clk);
      sample(0, v, rd, dn, bs, g, r, c, ad);
      vectors++;
      if (v !== 1'b0 || rd !== 1'b0 || bs !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_idle cyc=%0d got gv=%b rd=%b busy=%b want 0", cy, v, rd, bs);
      end
    end
    @(posedge clk); #1;
    st_pat = '0; st_pat[0] = 1'b1; pz_pat = '0;
    run_frame(0, st_pat, pz_pat, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_start_while_busy();
    test_no_hblank();
    test_pad_no_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
